corr_readout_sched: RTL and testbench

CORR_READOUT_SCHED -- requirements
Module: corr_readout_sched

---
 rtl/ssc_pkg.sv | 37 +++
 rtl/corr_readout_sched_if.sv | 26 ++
 rtl/rr_pick.sv | 32 +++
 rtl/corr_readout_sched.sv | 171 +++++++++++++++++
 tb/tb_corr_readout_sched.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssc_pkg.sv
// Shared types and constants for the correlator readout scheduler:
// sequencer states, per-channel register offsets and record layout.
package ssc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_RD_CNT = 3'd2,
        ST_RD_LO  = 3'd3,
        ST_RD_HI  = 3'd4,
        ST_CLR    = 3'd5,
        ST_PUSH   = 3'd6
    } state_t;

    localparam logic [15:0] OFS_CNT = 16'h0000;
    localparam logic [15:0] OFS_LO  = 16'h0004;
    localparam logic [15:0] OFS_HI  = 16'h0008;
    localparam logic [15:0] OFS_CLR = 16'h000C;

    localparam int CHAN_W = 8;
    localparam int WORD_W = 32;
    localparam int REC_W  = CHAN_W + 3 * WORD_W;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic [WORD_W-1:0] cnt;
        logic [WORD_W-1:0] high;
        logic [WORD_W-1:0] low;
    } rec_t;

    // All terms are 16 bits so the sum wraps modulo 2^16.
    function automatic logic [15:0] reg_addr(input logic [15:0] base, input logic [15:0] stride,
                                             input logic [15:0] chan, input logic [15:0] ofs);
        return base + chan * stride + ofs;
    endfunction

endpackage

// File: rtl/corr_readout_sched_if.sv
// Register-bus and record-output bundle between the readout scheduler
// (master) and the host side (slave).
interface corr_readout_sched_if;

    logic                          bus_req;
    logic                          bus_gnt;
    logic [31:0]                   addr;
    logic                          read;
    logic                          write;
    logic [ssc_pkg::WORD_W-1:0]    wdata;
    logic [ssc_pkg::WORD_W-1:0]    rdata;
    logic                          rec_valid;
    logic                          rec_ready;
    logic [ssc_pkg::REC_W-1:0]     rec_data;

    modport master (
        output bus_req, addr, read, write, wdata, rec_valid, rec_data,
        input  bus_gnt, rdata, rec_ready
    );

    modport slave (
        input  bus_req, addr, read, write, wdata, rec_valid, rec_data,
        output bus_gnt, rdata, rec_ready
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last',
// wrapping at NCH, returned as one-hot grant and index.
module rr_pick #(
    parameter int NCH = 10,
    parameter int IW  = 4
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx
);

    // Scan last+1 .. last+NCH; the first hit masks all later candidates
    always_comb begin
        int   k;
        logic hit;
        logic take;
        gnt  = '0;
        idx  = '0;
        hit  = 1'b0;
        take = 1'b0;
        k    = 0;
        for (int i = 1; i <= NCH; i++) begin
            k             = (int'(last) + i) % NCH;
            take          = req[IW'(k)] & ~hit;
            gnt[IW'(k)]   = take;
            idx           = take ? IW'(k) : idx;
            hit           = hit | take;
        end
    end

endmodule

// File: rtl/corr_readout_sched.sv
// Correlator readout scheduler: latches per-channel correlation events, then
// reads count/low/high over the shared bus, clears the count and emits a record.
module corr_readout_sched
    import ssc_pkg::*;
#(
    parameter int          NCH       = 10,
    parameter logic [15:0] CORR_BASE = 16'h0690,
    parameter logic [15:0] CH_STRIDE = 16'h0010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH-1:0]       cseen,
    corr_readout_sched_if.master bus,
    output logic [7:0]           ovf_cnt
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t            state_r, state_s;
    logic [IW-1:0]     chan_r, chan_s, last_r, pick_idx_s;
    logic [NCH-1:0]    pend_r, prev_r, rise_s, clr_mask_s, pick_gnt_s;
    logic [WORD_W-1:0] cnt_r, lo_r, hi_r;
    logic [7:0]        ovf_r;
    logic              ovf_inc_s;
    logic              bus_req_r, read_r, write_r, rec_valid_r;
    logic              bus_req_s, read_s, write_s, rec_valid_s;
    logic [15:0]       addr_r, addr_s;
    rec_t              rec_r, rec_s;

    rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
        .req  (pend_r),
        .last (last_r),
        .gnt  (pick_gnt_s),
        .idx  (pick_idx_s)
    );

    // Edge detect; a pending bit is released only when its clear write is granted
    always_comb begin
        rise_s     = cseen & ~prev_r;
        clr_mask_s = '0;
        if (state_r == ST_CLR && bus.bus_gnt) begin
            clr_mask_s = NCH'(1) << chan_r;
        end else begin
            clr_mask_s = '0;
        end
        ovf_inc_s = |(rise_s & pend_r & ~clr_mask_s);
    end

    // Sequencer next state; any grant loss mid-sequence restarts from the count read
    always_comb begin
        state_s = state_r;
        chan_s  = chan_r;
        case (state_r)
            ST_IDLE: begin
                if (en && (|pick_gnt_s)) begin
                    state_s = ST_REQ;
                    chan_s  = pick_idx_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ:    state_s = bus.bus_gnt ? ST_RD_CNT : ST_REQ;
            ST_RD_CNT: state_s = bus.bus_gnt ? ST_RD_LO  : ST_REQ;
            ST_RD_LO:  state_s = bus.bus_gnt ? ST_RD_HI  : ST_REQ;
            ST_RD_HI:  state_s = bus.bus_gnt ? ST_CLR    : ST_REQ;
            ST_CLR:    state_s = bus.bus_gnt ? ST_PUSH   : ST_REQ;
            ST_PUSH:   state_s = bus.rec_ready ? ST_IDLE : ST_PUSH;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every bus output leaves a flop
    always_comb begin
        bus_req_s   = 1'b0;
        read_s      = 1'b0;
        write_s     = 1'b0;
        rec_valid_s = 1'b0;
        addr_s      = 16'h0000;
        rec_s       = '0;
        case (state_s)
            ST_REQ: bus_req_s = 1'b1;
            ST_RD_CNT: begin
                bus_req_s = 1'b1;
                read_s    = 1'b1;
                addr_s    = reg_addr(CORR_BASE, CH_STRIDE, 16'(chan_s), OFS_CNT);
            end
            ST_RD_LO: begin
                bus_req_s = 1'b1;
                read_s    = 1'b1;
                addr_s    = reg_addr(CORR_BASE, CH_STRIDE, 16'(chan_s), OFS_LO);
            end
            ST_RD_HI: begin
                bus_req_s = 1'b1;
                read_s    = 1'b1;
                addr_s    = reg_addr(CORR_BASE, CH_STRIDE, 16'(chan_s), OFS_HI);
            end
            ST_CLR: begin
                bus_req_s = 1'b1;
                write_s   = 1'b1;
                addr_s    = reg_addr(CORR_BASE, CH_STRIDE, 16'(chan_s), OFS_CLR);
            end
            ST_PUSH: begin
                rec_valid_s = 1'b1;
                rec_s       = '{chan: CHAN_W'(chan_s), cnt: cnt_r, high: hi_r, low: lo_r};
            end
            default: bus_req_s = 1'b0;
        endcase
    end

    // Sequencer, pending/overflow bookkeeping and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            chan_r  <= '0;
            last_r  <= IW'(NCH - 1);
            pend_r  <= '0;
            prev_r  <= '0;
            cnt_r   <= '0;
            lo_r    <= '0;
            hi_r    <= '0;
            ovf_r   <= 8'h00;
        end else begin
            state_r <= state_s;
            chan_r  <= chan_s;
            prev_r  <= cseen;
            pend_r  <= (pend_r & ~clr_mask_s) | rise_s;
            if (ovf_inc_s && ovf_r != 8'hFF) begin
                ovf_r <= ovf_r + 8'h01;
            end
            if (bus.bus_gnt) begin
                case (state_r)
                    ST_RD_CNT: cnt_r  <= bus.rdata;
                    ST_RD_LO:  lo_r   <= bus.rdata;
                    ST_RD_HI:  hi_r   <= bus.rdata;
                    ST_CLR:    last_r <= chan_r;
                    default:   last_r <= last_r;
                endcase
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req_r   <= 1'b0;
            read_r      <= 1'b0;
            write_r     <= 1'b0;
            rec_valid_r <= 1'b0;
            addr_r      <= 16'h0000;
            rec_r       <= '0;
        end else begin
            bus_req_r   <= bus_req_s;
            read_r      <= read_s;
            write_r     <= write_s;
            rec_valid_r <= rec_valid_s;
            addr_r      <= addr_s;
            rec_r       <= rec_s;
        end
    end

    assign bus.bus_req   = bus_req_r;
    assign bus.read      = read_r;
    assign bus.write     = write_r;
    assign bus.addr      = {16'h0000, addr_r};
    assign bus.wdata     = 32'h0000_0000;
    assign bus.rec_valid = rec_valid_r;
    assign bus.rec_data  = rec_r;
    assign ovf_cnt       = ovf_r;

endmodule

// File: tb/tb_corr_readout_sched.sv
// Directed and randomized checks of corr_readout_sched against a bus-slave
// model, expected register addresses and event-conservation accounting.
module tb_corr_readout_sched;

    localparam int          NCH    = 10;
    localparam logic [15:0] BASE   = 16'h0690;
    localparam logic [15:0] STRIDE = 16'h0010;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [NCH-1:0] cseen;
    logic [7:0]     ovf_cnt;

    corr_readout_sched_if bus();

    corr_readout_sched #(.NCH(NCH), .CORR_BASE(BASE), .CH_STRIDE(STRIDE)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cseen   (cseen),
        .bus     (bus),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic        dir_mode = 1'b1;
    logic [31:0] salt     = 32'h0;

    // Host register file: directed mode returns 11/22/33 at +0/+4/+8
    assign bus.rdata = !bus.read ? 32'h0 :
                       dir_mode  ? 32'd11 * (32'(bus.addr[3:2]) + 32'd1) :
                                   salt ^ {bus.addr[15:0], bus.addr[15:0]};

    function automatic logic [31:0] rdata_fn(input logic [15:0] a);
        if (dir_mode) return 32'd11 * (32'(a[3:2]) + 32'd1);
        else          return salt ^ {a, a};
    endfunction

    function automatic logic [15:0] exp_addr(input int ch, input int ofs);
        logic [15:0] a;
        a = BASE + STRIDE * 16'(ch) + 16'(ofs);
        return a;
    endfunction

    function automatic logic [103:0] exp_rec(input int ch);
        return {8'(ch), rdata_fn(exp_addr(ch, 0)), rdata_fn(exp_addr(ch, 8)), rdata_fn(exp_addr(ch, 4))};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [103:0] rec_q[$];
    logic [15:0]  rd_q[$];
    logic [15:0]  wr_q[$];
    int           rw_both    = 0;
    int           strobe_bad = 0;

    // Bus/record monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.rec_valid && bus.rec_ready) rec_q.push_back(bus.rec_data);
        if (bus.read)  rd_q.push_back(bus.addr[15:0]);
        if (bus.write) wr_q.push_back(bus.addr[15:0]);
        if (bus.read && bus.write) rw_both <= rw_both + 1;
        if ((!bus.read && !bus.write && bus.addr != 32'h0) || bus.wdata != 32'h0 || bus.addr[31:16] != 16'h0)
            strobe_bad <= strobe_bad + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_recs(input int n, input int bound, input string tag);
        int k;
        k = 0;
        while (rec_q.size() < n && k < bound) begin
            step();
            k++;
        end
        chk(tag, 128'(rec_q.size() >= n), 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int             k, ch, total_rises;
        int             rises_ch[NCH];
        int             recs_ch[NCH];
        logic [103:0]   held;
        logic           stable, ok_ch;
        logic [NCH-1:0] nxt;

        rst = 1'b1; en = 1'b0; cseen = '0;
        bus.bus_gnt = 1'b0; bus.rec_ready = 1'b0;
        steps(3);
        chk("rst_ctl",  {bus.bus_req, bus.read, bus.write, bus.rec_valid, ovf_cnt}, 128'd0);
        chk("rst_addr", {bus.addr, bus.wdata}, 128'd0);
        chk("rst_rec",  bus.rec_data, 128'd0);
        rst = 1'b0; en = 1'b1; bus.bus_gnt = 1'b1; bus.rec_ready = 1'b1;
        steps(3);
        chk("idle_noreq", bus.bus_req, 128'd0);

        // Best-case sequence on channel 3
        cseen[3] = 1'b1;
        step(); chk("t1_e1", bus.bus_req, 128'd0);
        step(); chk("t1_req", {bus.bus_req, bus.read}, 128'b10);
        step(); chk("t1_rd_cnt", {bus.read, bus.write, bus.addr}, {1'b1, 1'b0, 32'h0000_06C0});
        step(); chk("t1_rd_lo",  {bus.read, bus.write, bus.addr}, {1'b1, 1'b0, 32'h0000_06C4});
        step(); chk("t1_rd_hi",  {bus.read, bus.write, bus.addr}, {1'b1, 1'b0, 32'h0000_06C8});
        step(); chk("t1_clr", {bus.bus_req, bus.read, bus.write, bus.addr, bus.wdata}, {1'b1, 1'b0, 1'b1, 32'h0000_06CC, 32'h0});
        step(); chk("t1_push", {bus.rec_valid, bus.bus_req}, 128'b10);
        chk("t1_rec", bus.rec_data, {8'd3, 32'd11, 32'd33, 32'd22});
        step(); chk("t1_done", bus.rec_valid, 128'd0);
        cseen = '0;

        // Round robin: ch0 and ch9 together after ch9 was served
        dir_mode = 1'b0; salt = $urandom;
        rec_q.delete();
        cseen[9] = 1'b1;
        wait_recs(1, 40, "t2_pre_timeout");
        cseen = '0;
        chk("t2_pre_chan", rec_q[0][103:96], 128'd9);
        rec_q.delete();
        step();
        cseen[0] = 1'b1; cseen[9] = 1'b1;
        wait_recs(2, 60, "t2_timeout");
        chk("t2_first",  rec_q[0], exp_rec(0));
        chk("t2_second", rec_q[1], exp_rec(9));
        cseen = '0;

        // Grant loss during the low-word read
        steps(3);
        rec_q.delete(); rd_q.delete(); wr_q.delete();
        cseen[2] = 1'b1;
        steps(4);
        chk("t3_rd_lo", bus.addr, 128'h06B4);
        bus.bus_gnt = 1'b0;
        step();
        chk("t3_back_req", {bus.bus_req, bus.read}, 128'b10);
        bus.bus_gnt = 1'b1;
        wait_recs(1, 30, "t3_timeout");
        steps(3);
        chk("t3_one_rec", rec_q.size(), 128'd1);
        chk("t3_rec", rec_q[0], exp_rec(2));
        chk("t3_nreads", rd_q.size(), 128'd5);
        chk("t3_reread", {rd_q[2], rd_q[3], rd_q[4]}, {16'h06B0, 16'h06B4, 16'h06B8});
        chk("t3_write", {32'(wr_q.size()), wr_q[0]}, {32'd1, 16'h06BC});
        cseen = '0;

        // Record back-pressure with a new event arriving meanwhile
        rec_q.delete();
        step();
        bus.rec_ready = 1'b0;
        cseen[4] = 1'b1;
        k = 0;
        while (!bus.rec_valid && k < 30) begin
            step();
            k++;
        end
        chk("t4_valid", bus.rec_valid, 128'd1);
        held = bus.rec_data;
        chk("t4_rec", held, exp_rec(4));
        cseen[6] = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            step();
            if (!(bus.rec_valid === 1'b1 && bus.rec_data === held && bus.bus_req === 1'b0 &&
                  bus.read === 1'b0 && bus.write === 1'b0))
                stable = 1'b0;
        end
        chk("t4_hold", stable, 128'd1);
        bus.rec_ready = 1'b1;
        wait_recs(2, 40, "t4_timeout");
        chk("t4_second", rec_q[1], exp_rec(6));
        cseen = '0;

        // Overflow saturation while service is disabled
        steps(3);
        chk("t5_ovf0", ovf_cnt, 128'd0);
        en = 1'b0;
        cseen[5] = 1'b1;
        step();
        for (int i = 1; i <= 300; i++) begin
            cseen[5] = 1'b0; step();
            cseen[5] = 1'b1; step();
            if (i == 100) chk("t5_ovf100", ovf_cnt, 128'd100);
        end
        chk("t5_ovf_sat", ovf_cnt, 128'd255);
        chk("t5_no_svc", bus.bus_req, 128'd0);
        rec_q.delete();
        cseen = '0; en = 1'b1;
        wait_recs(1, 40, "t5_timeout");
        chk("t5_rec", rec_q[0], exp_rec(5));

        // Reset while reading the high word
        steps(3);
        rec_q.delete();
        cseen[1] = 1'b1;
        steps(5);
        chk("t7_rd_hi", {bus.read, bus.addr}, {1'b1, 32'h0000_06A8});
        rst = 1'b1; cseen = '0;
        #1;
        chk("t7_async", {bus.bus_req, bus.read, bus.write, bus.rec_valid}, 128'd0);
        step();
        chk("t7_next", {bus.bus_req, bus.read, bus.write, bus.rec_valid, bus.addr, bus.wdata}, 128'd0);
        rst = 1'b0;
        steps(30);
        chk("t7_no_rec", rec_q.size(), 128'd0);
        chk("t7_idle", bus.bus_req, 128'd0);
        chk("t7_ovf_clr", ovf_cnt, 128'd0);

        // Random events, grants, back-pressure and enable
        rec_q.delete();
        total_rises = 0;
        for (int b = 0; b < NCH; b++) begin
            rises_ch[b] = 0;
            recs_ch[b]  = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            nxt = cseen;
            for (int b = 0; b < NCH; b++) begin
                if ($urandom_range(0, 199) == 0) nxt[b] = ~nxt[b];
                if (nxt[b] && !cseen[b]) rises_ch[b]++;
            end
            total_rises += $countones(nxt & ~cseen);
            cseen         = nxt;
            bus.bus_gnt   = ($urandom_range(0, 7) != 0);
            bus.rec_ready = ($urandom_range(0, 3) != 0);
            en            = ($urandom_range(0, 15) != 0);
            step();
        end
        bus.bus_gnt = 1'b1; bus.rec_ready = 1'b1; en = 1'b1;
        steps(300);
        chk("t6_some_recs", 128'(rec_q.size() > 0), 128'd1);
        chk("t6_conserve", rec_q.size() + int'(ovf_cnt), total_rises);
        for (int i = 0; i < rec_q.size(); i++) begin
            ch = int'(rec_q[i][103:96]);
            chk("t6_chan_range", 128'(ch < NCH), 128'd1);
            if (ch < NCH) begin
                recs_ch[ch]++;
                chk($sformatf("t6_rec%0d", i), rec_q[i], exp_rec(ch));
            end
        end
        ok_ch = 1'b1;
        for (int b = 0; b < NCH; b++) begin
            if (recs_ch[b] > rises_ch[b]) ok_ch = 1'b0;
        end
        chk("t6_per_chan", ok_ch, 128'd1);
        chk("t6_idle", {bus.bus_req, bus.rec_valid}, 128'd0);

        chk("rw_exclusive", rw_both, 128'd0);
        chk("strobe_clean", strobe_bad, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
